cachepool_coalescer: RTL and testbench
======================================

# cachepool_coalescer

Read coalescer between a core's 32-bit data port and its L1 cache controller in the CachePool tile. It gathers up to `CoalFactor` read requests to the same 128-bit cache line within a short window and issues them as one line request. When the line returns, it splits the data back into per-request word responses, delivered in arrival order. Writes bypass coalescing and are issued as single masked line requests. One line request is outstanding at a time.

## Interface
- `AddrWidth`, default 32: byte address width.
- `DataWidth`, default 32: core word width.
- `LineWidth`, default 128: L1 line width. Must be a power-of-two multiple of `DataWidth`.
- `CoalFactor`, default 2: maximum number of requests merged into one line request. Must be ≥1.
- `WindowCycles`, default 2: maximum number of idle gather cycles. Must be ≥1.
- `IdWidth`, default 4: request tag width.
- `clk_i` in, 1: clock.
- `rst_i` in, 1: asynchronous, active-high reset.
- `req_valid_i` / `req_ready_o`, in/out, 1: core request handshake.
- `req_addr_i` in, AddrWidth: byte address.
- `req_write_i` in, 1: 1 = write.
- `req_wdata_i` in, DataWidth: write data.
- `req_be_i` in, DataWidth/8: byte enables.
- `req_id_i` in, IdWidth: tag echoed in the response.
- `rsp_valid_o` / `rsp_ready_i`, out/in, 1: core response handshake.
- `rsp_data_o` out, DataWidth: read word (0 for writes).
- `rsp_id_o` out, IdWidth: echoed tag.
- `line_valid_o` / `line_ready_i`, out/in, 1: line request handshake to the controller.
- `line_addr_o` out, AddrWidth: line-aligned address, with the low log2(LineWidth/8) bits set to 0.
- `line_write_o` out, 1: write flag.
- `line_wdata_o` out, LineWidth: write word replicated into every lane.
- `line_be_o` out, LineWidth/8: byte enables. For a write, `req_be_i` is placed in lane `addr[log2(LineWidth/8)-1:log2(DataWidth/8)]` and all other bits are 0. For a read, all ones.
- `line_rsp_valid_i` / `line_rsp_ready_o`, in/out, 1: line response handshake.
- `line_rsp_data_i` in, LineWidth: returned line data.

## Operation
- Internal buffer: `CoalFactor` entries of {lane index, id, write}, a line address, a count (1..CoalFactor), a wait counter, and a captured line.
- **IDLE**: `req_ready_o`=1.
  - On accepting a read: store it, set count=1, clear the wait counter, go to GATHER.
  - On accepting a write: store it, go to ISSUE.
- **GATHER**: `req_ready_o`=1 only if the incoming request is a read, targets the same line address, and count<CoalFactor.
  - If that request is accepted and count+1==CoalFactor: go to ISSUE.
  - Else, if `req_valid_i` is high with a non-coalescable request (write or different line): go to ISSUE without accepting it.
  - Else, if the wait counter equals WindowCycles-1: go to ISSUE.
  - Otherwise increment the wait counter. An accept does not clear the wait counter.
  - If CoalFactor==1, a read goes from IDLE directly to ISSUE.
- **ISSUE**: `line_valid_o`=1 with stable payload until `line_ready_i`, then go to WAIT. `req_ready_o`=0.
- **WAIT**: `line_rsp_ready_o`=1. On `line_rsp_valid_i`, capture `line_rsp_data_i` and go to RESPOND. `line_rsp_ready_o` is 0 in every other state.
- **RESPOND**: present buffer entries in arrival order.
  - `rsp_data_o` = the captured line lane selected by the entry's lane index, or 0 for a write.
  - `rsp_id_o` = the entry's id.
  - Advance on each `rsp_ready_i` handshake. After the last entry, go to IDLE.
- Duplicate word addresses coalesce, and each request receives the same word.
- Reset, asynchronous and at any time: state becomes IDLE and all counters and buffers are cleared. In-flight requests are dropped with no responses. All outputs read 0 while `rst_i`=1, including `req_ready_o`.

## Timing
- A read accepted alone at cycle T: GATHER spans T+1..T+WindowCycles, and `line_valid_o` rises at T+WindowCycles+1.
- A read at T followed by the CoalFactor-th read accepted at T+k: `line_valid_o` rises at T+k+1.
- A write accepted at T: `line_valid_o` rises at T+1.
- A line handshake at U: WAIT begins at U+1.
- A line response handshake at V: the first `rsp_valid_o` appears at V+1. Each further response follows one cycle after the previous handshake if `rsp_ready_i` stays high.
- The cycle after the final response handshake is IDLE, and a new request can be accepted in that cycle.
- All outputs are driven combinationally from registered state. There is no combinational path from `line_*` inputs to `req_*` outputs.

## Test plan
- **Pair merge:** reads id 1 @0x8000_0004 at T and id 2 @0x8000_0008 at T+1, line_ready=1, line response 0xDDDD_CCCC_BBBB_AAAA_…_0003_0002_0001_0000 style pattern (lane n = n).
  - Required: one line request with addr 0x8000_0000 at T+2, be=0xFFFF.
  - Required: responses (1, lane1) then (2, lane2).
- **Window timeout:** single read id 3 @0x8000_0010, WindowCycles=2, no further input.
  - Required: `line_valid_o` at T+3, one response with id 3.
- **Line break:** read @0x8000_0000, then read @0x8000_0010 held valid.
  - Required: the second read stalls (`req_ready_o`=0) until RESPOND completes, then is accepted in IDLE. Two separate line requests.
- **Write bypass:** write id 5 @0x8000_000C, data 0xCAFE_F00D, be=0xF.
  - Required: `line_valid_o` at T+1, `line_write_o`=1, be=0xF000, wdata replicated 4×.
  - Required: after the line response, a response with id 5 and data 0.
- **Backpressure:** hold `line_ready_i`=0 for 5 cycles and `rsp_ready_i`=0 for 3 cycles.
  - Required: payloads stable, no lost or duplicated responses, order preserved.
- **Reset mid-WAIT:** assert `rst_i` after the line handshake.
  - Required: all outputs 0 immediately, state IDLE after release, no responses emitted, and a late `line_rsp_valid_i` is ignored (`line_rsp_ready_o`=0).

Source files
------------

// File: rtl/cachepool_coalescer.sv
// Read coalescer: gathers same-line reads from a 32-bit core port into single
// L1 line requests, splits the returned line back into in-order word responses,
// and forwards writes as single masked line requests.
module cachepool_coalescer #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned CoalFactor   = 2,
  parameter int unsigned WindowCycles = 2,
  parameter int unsigned IdWidth      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // core request
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [AddrWidth-1:0]     req_addr_i,
  input  logic                     req_write_i,
  input  logic [DataWidth-1:0]     req_wdata_i,
  input  logic [DataWidth/8-1:0]   req_be_i,
  input  logic [IdWidth-1:0]       req_id_i,
  // core response
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DataWidth-1:0]     rsp_data_o,
  output logic [IdWidth-1:0]       rsp_id_o,
  // line request to the cache controller
  output logic                     line_valid_o,
  input  logic                     line_ready_i,
  output logic [AddrWidth-1:0]     line_addr_o,
  output logic                     line_write_o,
  output logic [LineWidth-1:0]     line_wdata_o,
  output logic [LineWidth/8-1:0]   line_be_o,
  // line response from the cache controller
  input  logic                     line_rsp_valid_i,
  output logic                     line_rsp_ready_o,
  input  logic [LineWidth-1:0]     line_rsp_data_i
);

  localparam int unsigned Lanes   = LineWidth / DataWidth;
  localparam int unsigned LaneW   = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam int unsigned BeW     = DataWidth / 8;
  localparam int unsigned LineBeW = LineWidth / 8;
  localparam int unsigned ByteOff = $clog2(BeW);
  localparam int unsigned LineOff = $clog2(LineBeW);
  localparam int unsigned CntW    = $clog2(CoalFactor + 1);
  localparam int unsigned IdxW    = (CoalFactor > 1) ? $clog2(CoalFactor) : 1;
  localparam int unsigned WaitW   = (WindowCycles > 1) ? $clog2(WindowCycles) : 1;
  localparam logic [AddrWidth-1:0] LineMask =
    ~AddrWidth'((64'd1 << LineOff) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_ISSUE,
    S_WAIT,
    S_RESPOND
  } state_e;

  state_e state, state_d;

  // Coalescing buffer
  logic [AddrWidth-1:0] line_addr;
  logic [LaneW-1:0]     ent_lane  [CoalFactor];
  logic [IdWidth-1:0]   ent_id    [CoalFactor];
  logic                 ent_write [CoalFactor];
  logic [CntW-1:0]      count;
  logic [WaitW-1:0]     wait_cnt;
  logic [IdxW-1:0]      rsp_idx;
  logic [DataWidth-1:0] wdata;
  logic [BeW-1:0]       be;
  logic [LineWidth-1:0] line_q;

  // Control strobes from the FSM to the datapath
  logic take_first, take_more, wait_inc, capture, rsp_adv;

  logic [AddrWidth-1:0] req_line;
  logic [LaneW-1:0]     req_lane;
  logic                 same_line_rd;
  logic                 window_done;
  logic                 last_rsp;
  logic [LineBeW-1:0]   be_lane;
  logic [DataWidth-1:0] lane_words [Lanes];

  assign req_line     = req_addr_i & LineMask;
  assign req_lane     = LaneW'(req_addr_i >> ByteOff);
  assign same_line_rd = !req_write_i && (req_line == line_addr)
                        && (count < CntW'(CoalFactor));
  assign window_done  = (wait_cnt == WaitW'(WindowCycles - 1));
  assign last_rsp     = ((CntW'(rsp_idx) + CntW'(1)) == count);

  // Split the captured line into word lanes
  for (genvar l = 0; l < Lanes; l++) begin : g_lanes
    assign lane_words[l] = line_q[l*DataWidth +: DataWidth];
  end

  // Place the write byte enables into the addressed lane
  always_comb begin
    be_lane = '0;
    for (int l = 0; l < Lanes; l++) begin
      if (ent_lane[0] == LaneW'(l)) be_lane[l*BeW +: BeW] = be;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state, control strobes and outputs; everything reads 0 during reset
  always_comb begin
    state_d          = state;
    take_first       = 1'b0;
    take_more        = 1'b0;
    wait_inc         = 1'b0;
    capture          = 1'b0;
    rsp_adv          = 1'b0;
    req_ready_o      = 1'b0;
    rsp_valid_o      = 1'b0;
    rsp_data_o       = '0;
    rsp_id_o         = '0;
    line_valid_o     = 1'b0;
    line_addr_o      = '0;
    line_write_o     = 1'b0;
    line_wdata_o     = '0;
    line_be_o        = '0;
    line_rsp_ready_o = 1'b0;
    if (!rst_i) begin
      case (state)
        S_IDLE: begin
          req_ready_o = 1'b1;
          if (req_valid_i) begin
            take_first = 1'b1;
            if (req_write_i || (CoalFactor == 1)) state_d = S_ISSUE;
            else                                   state_d = S_GATHER;
          end
        end
        S_GATHER: begin
          req_ready_o = same_line_rd;
          if (req_valid_i && same_line_rd) begin
            take_more = 1'b1;
            if ((count + CntW'(1)) == CntW'(CoalFactor)) state_d = S_ISSUE;
            else if (window_done)                        state_d = S_ISSUE;
            else                                         wait_inc = 1'b1;
          end else if (req_valid_i) begin
            state_d = S_ISSUE;
          end else if (window_done) begin
            state_d = S_ISSUE;
          end else begin
            wait_inc = 1'b1;
          end
        end
        S_ISSUE: begin
          line_valid_o = 1'b1;
          line_addr_o  = line_addr;
          line_write_o = ent_write[0];
          line_wdata_o = {Lanes{wdata}};
          line_be_o    = ent_write[0] ? be_lane : '1;
          if (line_ready_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          line_rsp_ready_o = 1'b1;
          if (line_rsp_valid_i) begin
            capture = 1'b1;
            state_d = S_RESPOND;
          end
        end
        S_RESPOND: begin
          rsp_valid_o = 1'b1;
          rsp_id_o    = ent_id[rsp_idx];
          rsp_data_o  = ent_write[rsp_idx] ? '0 : lane_words[ent_lane[rsp_idx]];
          if (rsp_ready_i) begin
            rsp_adv = 1'b1;
            if (last_rsp) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Buffer, counters and captured line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_addr <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      rsp_idx   <= '0;
      wdata     <= '0;
      be        <= '0;
      line_q    <= '0;
      for (int i = 0; i < CoalFactor; i++) begin
        ent_lane[i]  <= '0;
        ent_id[i]    <= '0;
        ent_write[i] <= 1'b0;
      end
    end else begin
      if (take_first) begin
        line_addr    <= req_line;
        ent_lane[0]  <= req_lane;
        ent_id[0]    <= req_id_i;
        ent_write[0] <= req_write_i;
        wdata        <= req_wdata_i;
        be           <= req_be_i;
        count        <= CntW'(1);
        wait_cnt     <= '0;
      end
      if (take_more) begin
        ent_lane[IdxW'(count)]  <= req_lane;
        ent_id[IdxW'(count)]    <= req_id_i;
        ent_write[IdxW'(count)] <= 1'b0;
        count                   <= count + CntW'(1);
      end
      if (wait_inc) wait_cnt <= wait_cnt + WaitW'(1);
      if (capture) begin
        line_q  <= line_rsp_data_i;
        rsp_idx <= '0;
      end
      if (rsp_adv) rsp_idx <= rsp_idx + IdxW'(1);
    end
  end

endmodule

// File: tb/tb_cachepool_coalescer.sv
// Directed bench for cachepool_coalescer (default parameters).
module tb_cachepool_coalescer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [31:0]  req_addr_i;
  logic         req_write_i;
  logic [31:0]  req_wdata_i;
  logic [3:0]   req_be_i;
  logic [3:0]   req_id_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [31:0]  rsp_data_o;
  logic [3:0]   rsp_id_o;
  logic         line_valid_o;
  logic         line_ready_i;
  logic [31:0]  line_addr_o;
  logic         line_write_o;
  logic [127:0] line_wdata_o;
  logic [15:0]  line_be_o;
  logic         line_rsp_valid_i;
  logic         line_rsp_ready_o;
  logic [127:0] line_rsp_data_i;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LINE_A = 128'h3333_0003_2222_0002_1111_0001_0A0A_0000;
  localparam logic [127:0] LINE_B = 128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000;

  cachepool_coalescer dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .req_write_i      (req_write_i),
    .req_wdata_i      (req_wdata_i),
    .req_be_i         (req_be_i),
    .req_id_i         (req_id_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .rsp_id_o         (rsp_id_o),
    .line_valid_o     (line_valid_o),
    .line_ready_i     (line_ready_i),
    .line_addr_o      (line_addr_o),
    .line_write_o     (line_write_o),
    .line_wdata_o     (line_wdata_o),
    .line_be_o        (line_be_o),
    .line_rsp_valid_i (line_rsp_valid_i),
    .line_rsp_ready_o (line_rsp_ready_o),
    .line_rsp_data_i  (line_rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Move 1 ns past the next rising edge; inputs are then driven and outputs
  // sampled 1 ns later, well away from either edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic read_req(input logic [31:0] addr, input logic [3:0] id);
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = addr;
    req_id_i    = id;
    req_wdata_i = '0;
    req_be_i    = 4'hF;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({req_ready_o, line_valid_o, line_rsp_ready_o, rsp_valid_o, line_be_o, line_addr_o} !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b lv=%b lrr=%b rv=%b be=%h addr=%h, want all 0",
               req_ready_o, line_valid_o, line_rsp_ready_o, rsp_valid_o, line_be_o, line_addr_o);
    end
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, line_valid_o, rsp_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got rdy/lv/rv=%b want 100", {req_ready_o, line_valid_o, rsp_valid_o});
    end
  endtask

  task automatic test_pair_merge();
    line_ready_i = 1'b1;
    tick();                                    // T
    read_req(32'h8000_0004, 4'd1);
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL pair_first_ready: got %b want 1", req_ready_o);
    end
    tick();                                    // T+1 GATHER
    read_req(32'h8000_0008, 4'd2);
    #1;
    checks++;
    if ({req_ready_o, line_valid_o} !== 2'b10) begin
      errors++; $display("FAIL pair_second_ready: got rdy/lv=%b want 10", {req_ready_o, line_valid_o});
    end
    tick();                                    // T+2 ISSUE
    req_valid_i = 1'b0;
    #1;
    checks++;
    if ({line_valid_o, line_write_o, line_addr_o, line_be_o} !== {1'b1, 1'b0, 32'h8000_0000, 16'hFFFF}) begin
      errors++;
      $display("FAIL pair_issue: got lv=%b wr=%b addr=%h be=%h want 1 0 80000000 ffff",
               line_valid_o, line_write_o, line_addr_o, line_be_o);
    end
    tick();                                    // T+3 WAIT
    line_rsp_valid_i = 1'b1;
    line_rsp_data_i  = LINE_A;
    #1;
    checks++;
    if ({line_valid_o, line_rsp_ready_o} !== 2'b01) begin
      errors++; $display("FAIL pair_wait: got lv/lrr=%b want 01", {line_valid_o, line_rsp_ready_o});
    end
    tick();                                    // T+4 RESPOND
    line_rsp_valid_i = 1'b0;
    rsp_ready_i      = 1'b1;
    #1;
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 4'd1, 32'h1111_0001}) begin
      errors++; $display("FAIL pair_rsp0: got v=%b id=%h data=%h want 1 1 11110001", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    tick();                                    // T+5
    #1;
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 4'd2, 32'h2222_0002}) begin
      errors++; $display("FAIL pair_rsp1: got v=%b id=%h data=%h want 1 2 22220002", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    tick();                                    // T+6 IDLE
    rsp_ready_i = 1'b0;
    #1;
    checks++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      errors++; $display("FAIL pair_done: got rv/rdy=%b want 01", {rsp_valid_o, req_ready_o});
    end
  endtask

  task automatic test_window_timeout();
    tick();                                    // T
    read_req(32'h8000_0010, 4'd3);
    #1;
    tick();                                    // T+1
    req_valid_i = 1'b0;
    #1;
    checks++;
    if (line_valid_o !== 1'b0) begin
      errors++; $display("FAIL window_t1: got lv=%b want 0", line_valid_o);
    end
    tick();                                    // T+2
    #1;
    checks++;
    if (line_valid_o !== 1'b0) begin
      errors++; $display("FAIL window_t2: got lv=%b want 0", line_valid_o);
    end
    tick();                                    // T+3
    #1;
    checks++;
    if ({line_valid_o, line_addr_o} !== {1'b1, 32'h8000_0010}) begin
      errors++; $display("FAIL window_issue: got lv=%b addr=%h want 1 80000010", line_valid_o, line_addr_o);
    end
    tick();                                    // T+4 WAIT
    line_rsp_valid_i = 1'b1;
    line_rsp_data_i  = LINE_A;
    #1;
    tick();                                    // T+5 RESPOND
    line_rsp_valid_i = 1'b0;
    rsp_ready_i      = 1'b1;
    #1;
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 4'd3, 32'h0A0A_0000}) begin
      errors++; $display("FAIL window_rsp: got v=%b id=%h data=%h want 1 3 0a0a0000", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    tick();                                    // T+6
    rsp_ready_i = 1'b0;
    #1;
    checks++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      errors++; $display("FAIL window_single: got rv/rdy=%b want 01", {rsp_valid_o, req_ready_o});
    end
  endtask

  task automatic test_line_break();
    tick();                                    // T
    read_req(32'h8000_0000, 4'd4);
    #1;
    tick();                                    // T+1 GATHER, other line held
    read_req(32'h8000_0010, 4'd6);
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++; $display("FAIL break_stall_gather: got rdy=%b want 0", req_ready_o);
    end
    tick();                                    // T+2 ISSUE
    #1;
    checks++;
    if ({line_valid_o, req_ready_o, line_addr_o} !== {1'b1, 1'b0, 32'h8000_0000}) begin
      errors++; $display("FAIL break_issue1: got lv=%b rdy=%b addr=%h want 1 0 80000000", line_valid_o, req_ready_o, line_addr_o);
    end
    tick();                                    // T+3 WAIT
    line_rsp_valid_i = 1'b1;
    line_rsp_data_i  = LINE_B;
    #1;
    tick();                                    // T+4 RESPOND
    line_rsp_valid_i = 1'b0;
    rsp_ready_i      = 1'b1;
    #1;
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_data_o, req_ready_o} !== {1'b1, 4'd4, 32'hAAAA_0000, 1'b0}) begin
      errors++; $display("FAIL break_rsp1: got v=%b id=%h data=%h rdy=%b want 1 4 aaaa0000 0", rsp_valid_o, rsp_id_o, rsp_data_o, req_ready_o);
    end
    tick();                                    // T+5 IDLE accepts held read
    rsp_ready_i = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
      errors++; $display("FAIL break_accept: got rdy/rv=%b want 10", {req_ready_o, rsp_valid_o});
    end
    tick();                                    // T+6
    req_valid_i = 1'b0;
    #1;
    tick();                                    // T+7
    #1;
    checks++;
    if (line_valid_o !== 1'b0) begin
      errors++; $display("FAIL break_gather2: got lv=%b want 0", line_valid_o);
    end
    tick();                                    // T+8 ISSUE second line
    #1;
    checks++;
    if ({line_valid_o, line_addr_o} !== {1'b1, 32'h8000_0010}) begin
      errors++; $display("FAIL break_issue2: got lv=%b addr=%h want 1 80000010", line_valid_o, line_addr_o);
    end
    tick();                                    // T+9 WAIT
    line_rsp_valid_i = 1'b1;
    line_rsp_data_i  = LINE_A;
    #1;
    tick();                                    // T+10 RESPOND
    line_rsp_valid_i = 1'b0;
    rsp_ready_i      = 1'b1;
    #1;
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 4'd6, 32'h0A0A_0000}) begin
      errors++; $display("FAIL break_rsp2: got v=%b id=%h data=%h want 1 6 0a0a0000", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    tick();                                    // T+11
    rsp_ready_i = 1'b0;
    #1;
  endtask

  task automatic test_write_bypass();
    tick();                                    // T
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h8000_000C;
    req_wdata_i = 32'hCAFE_F00D;
    req_be_i    = 4'hF;
    req_id_i    = 4'd5;
    #1;
    tick();                                    // T+1 ISSUE
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    #1;
    checks++;
    if ({line_valid_o, line_write_o, line_addr_o, line_be_o} !== {1'b1, 1'b1, 32'h8000_0000, 16'hF000}) begin
      errors++; $display("FAIL write_issue: got lv=%b wr=%b addr=%h be=%h want 1 1 80000000 f000",
                         line_valid_o, line_write_o, line_addr_o, line_be_o);
    end
    checks++;
    if (line_wdata_o !== 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D) begin
      errors++; $display("FAIL write_wdata: got %h want cafef00d x4", line_wdata_o);
    end
    tick();                                    // T+2 WAIT
    line_rsp_valid_i = 1'b1;
    line_rsp_data_i  = LINE_B;
    #1;
    tick();                                    // T+3 RESPOND
    line_rsp_valid_i = 1'b0;
    rsp_ready_i      = 1'b1;
    #1;
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 4'd5, 32'h0}) begin
      errors++; $display("FAIL write_rsp: got v=%b id=%h data=%h want 1 5 00000000", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    tick();                                    // T+4
    rsp_ready_i = 1'b0;
    #1;
    checks++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      errors++; $display("FAIL write_done: got rv/rdy=%b want 01", {rsp_valid_o, req_ready_o});
    end
  endtask

  task automatic test_backpressure();
    line_ready_i = 1'b0;
    tick();                                    // T
    read_req(32'h8000_0020, 4'd7);
    #1;
    tick();                                    // T+1
    read_req(32'h8000_002C, 4'd8);
    #1;
    for (int i = 0; i < 5; i++) begin          // T+2..T+6 stalled ISSUE
      tick();
      req_valid_i = 1'b0;
      #1;
      checks++;
      if ({line_valid_o, line_addr_o, line_be_o, line_write_o} !== {1'b1, 32'h8000_0020, 16'hFFFF, 1'b0}) begin
        errors++; $display("FAIL bp_line_hold[%0d]: got lv=%b addr=%h be=%h wr=%b want 1 80000020 ffff 0",
                           i, line_valid_o, line_addr_o, line_be_o, line_write_o);
      end
    end
    tick();                                    // T+7 handshake
    line_ready_i = 1'b1;
    #1;
    tick();                                    // T+8 WAIT
    line_rsp_valid_i = 1'b1;
    line_rsp_data_i  = LINE_B;
    #1;
    for (int i = 0; i < 3; i++) begin          // T+9..T+11 response held
      tick();
      line_rsp_valid_i = 1'b0;
      rsp_ready_i      = 1'b0;
      #1;
      checks++;
      if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 4'd7, 32'hAAAA_0000}) begin
        errors++; $display("FAIL bp_rsp_hold[%0d]: got v=%b id=%h data=%h want 1 7 aaaa0000", i, rsp_valid_o, rsp_id_o, rsp_data_o);
      end
    end
    tick();                                    // T+12
    rsp_ready_i = 1'b1;
    #1;
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 4'd7, 32'hAAAA_0000}) begin
      errors++; $display("FAIL bp_rsp0: got v=%b id=%h data=%h want 1 7 aaaa0000", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    tick();                                    // T+13
    #1;
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 4'd8, 32'hDDDD_0003}) begin
      errors++; $display("FAIL bp_rsp1: got v=%b id=%h data=%h want 1 8 dddd0003", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    tick();                                    // T+14
    rsp_ready_i = 1'b0;
    #1;
    checks++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      errors++; $display("FAIL bp_done: got rv/rdy=%b want 01", {rsp_valid_o, req_ready_o});
    end
  endtask

  task automatic test_duplicate();
    tick();                                    // T
    read_req(32'h8000_0054, 4'd10);
    #1;
    tick();                                    // T+1
    read_req(32'h8000_0054, 4'd11);
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL dup_ready: got rdy=%b want 1", req_ready_o);
    end
    tick();                                    // T+2 ISSUE
    req_valid_i = 1'b0;
    #1;
    checks++;
    if ({line_valid_o, line_addr_o} !== {1'b1, 32'h8000_0050}) begin
      errors++; $display("FAIL dup_issue: got lv=%b addr=%h want 1 80000050", line_valid_o, line_addr_o);
    end
    tick();                                    // T+3 WAIT
    line_rsp_valid_i = 1'b1;
    line_rsp_data_i  = LINE_B;
    #1;
    tick();                                    // T+4
    line_rsp_valid_i = 1'b0;
    rsp_ready_i      = 1'b1;
    #1;
    checks++;
    if ({rsp_id_o, rsp_data_o} !== {4'd10, 32'hBBBB_0001}) begin
      errors++; $display("FAIL dup_rsp0: got id=%h data=%h want a bbbb0001", rsp_id_o, rsp_data_o);
    end
    tick();                                    // T+5
    #1;
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 4'd11, 32'hBBBB_0001}) begin
      errors++; $display("FAIL dup_rsp1: got v=%b id=%h data=%h want 1 b bbbb0001", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    tick();
    rsp_ready_i = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_wait();
    tick();                                    // T
    read_req(32'h8000_0040, 4'd9);
    #1;
    tick();                                    // T+1
    req_valid_i = 1'b0;
    #1;
    tick();                                    // T+2
    #1;
    tick();                                    // T+3 ISSUE, handshake
    #1;
    tick();                                    // T+4 WAIT
    #1;
    checks++;
    if (line_rsp_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstw_in_wait: got lrr=%b want 1", line_rsp_ready_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({req_ready_o, line_valid_o, line_rsp_ready_o, rsp_valid_o, line_be_o} !== 20'd0) begin
      errors++; $display("FAIL rstw_outputs: got rdy=%b lv=%b lrr=%b rv=%b be=%h want all 0",
                         req_ready_o, line_valid_o, line_rsp_ready_o, rsp_valid_o, line_be_o);
    end
    tick();
    rst_i            = 1'b0;
    line_rsp_valid_i = 1'b1;
    line_rsp_data_i  = LINE_A;
    rsp_ready_i      = 1'b1;
    #1;
    checks++;
    if ({req_ready_o, line_rsp_ready_o, rsp_valid_o} !== 3'b100) begin
      errors++; $display("FAIL rstw_idle: got rdy/lrr/rv=%b want 100", {req_ready_o, line_rsp_ready_o, rsp_valid_o});
    end
    tick();
    #1;
    checks++;
    if ({req_ready_o, line_rsp_ready_o, rsp_valid_o, line_valid_o} !== 4'b1000) begin
      errors++; $display("FAIL rstw_late_rsp: got rdy/lrr/rv/lv=%b want 1000",
                         {req_ready_o, line_rsp_ready_o, rsp_valid_o, line_valid_o});
    end
    line_rsp_valid_i = 1'b0;
    rsp_ready_i      = 1'b0;
  endtask

  initial begin
    rst_i            = 1'b1;
    req_valid_i      = 1'b0;
    req_addr_i       = '0;
    req_write_i      = 1'b0;
    req_wdata_i      = '0;
    req_be_i         = '0;
    req_id_i         = '0;
    rsp_ready_i      = 1'b0;
    line_ready_i     = 1'b0;
    line_rsp_valid_i = 1'b0;
    line_rsp_data_i  = '0;
    test_reset();
    test_pair_merge();
    test_window_timeout();
    test_line_break();
    test_write_bypass();
    test_backpressure();
    test_duplicate();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
